// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
package wb_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    // Result source for the register-file write.
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_t;

    // Load size/sign codes.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/load_extend.sv
// Load data extension: trims the LSB-aligned memory word to the access size
// and sign- or zero-extends it to the datapath width.
module load_extend #(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] raw_i,
    output logic [XLEN-1:0] ext_o
);
    import wb_pkg::*;

    // Size/sign selection; LD and the unused 111 code pass the word through.
    always_comb begin
        ext_o = raw_i;
        case (funct3_i)
            F3_LB:   ext_o = {{(XLEN-8){raw_i[7]}},   raw_i[7:0]};
            F3_LH:   ext_o = {{(XLEN-16){raw_i[15]}}, raw_i[15:0]};
            F3_LW:   ext_o = {{(XLEN-32){raw_i[31]}}, raw_i[31:0]};
            F3_LBU:  ext_o = {{(XLEN-8){1'b0}},       raw_i[7:0]};
            F3_LHU:  ext_o = {{(XLEN-16){1'b0}},      raw_i[15:0]};
            F3_LWU:  ext_o = {{(XLEN-32){1'b0}},      raw_i[31:0]};
            default: ext_o = raw_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, result select, x0 write suppression and the
// WB->ID bypass that covers the register file's write-then-read hazard.
// Optional macro WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter.
module writeback_stage #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [1:0]        mem_wb_sel,
    input  logic [2:0]        mem_funct3,
    input  logic [XLEN-1:0]   mem_alu_result,
    input  logic [XLEN-1:0]   mem_load_data,
    input  logic [XLEN-1:0]   mem_pc_plus4,
    input  logic              stall,
    input  logic              flush,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_write_data,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [XLEN-1:0]   id_rf_data1,
    input  logic [XLEN-1:0]   id_rf_data2,
    output logic [XLEN-1:0]   id_rs1_data,
    output logic [XLEN-1:0]   id_rs2_data
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]       retire_count
`endif
);
    import wb_pkg::*;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [REG_AW-1:0] rd;
        wb_sel_t           sel;
        logic [2:0]        funct3;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   load;
        logic [XLEN-1:0]   pc4;
    } memwb_t;

    memwb_t          memwb_q, memwb_d;
    logic [XLEN-1:0] load_ext;

    // Next MEM/WB contents: flush beats stall; a bubble clears every field.
    always_comb begin
        memwb_d = memwb_q;
        if (flush) begin
            memwb_d = '0;
        end else if (!stall) begin
            memwb_d.valid     = mem_valid;
            memwb_d.reg_write = mem_reg_write;
            memwb_d.rd        = mem_rd;
            memwb_d.sel       = wb_sel_t'(mem_wb_sel);
            memwb_d.funct3    = mem_funct3;
            memwb_d.alu       = mem_alu_result;
            memwb_d.load      = mem_load_data;
            memwb_d.pc4       = mem_pc_plus4;
        end
    end

    // MEM/WB register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) memwb_q <= '0;
        else          memwb_q <= memwb_d;
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3_i (memwb_q.funct3),
        .raw_i    (memwb_q.load),
        .ext_o    (load_ext)
    );

    // Write-back result select; the reserved code writes zero.
    always_comb begin
        wb_write_data = '0;
        case (memwb_q.sel)
            WB_ALU:  wb_write_data = memwb_q.alu;
            WB_LOAD: wb_write_data = load_ext;
            WB_PC4:  wb_write_data = memwb_q.pc4;
            default: wb_write_data = '0;
        endcase
    end

    // Bubbles and x0 destinations never reach the register file.
    assign wb_reg_write = memwb_q.valid & memwb_q.reg_write & (memwb_q.rd != '0);
    assign wb_rd        = memwb_q.rd;

    // ID operand bypass: x0 reads zero, a same-cycle WB write wins over the file.
    always_comb begin
        id_rs1_data = id_rf_data1;
        id_rs2_data = id_rf_data2;
        if (id_rs1 == '0)                             id_rs1_data = '0;
        else if (wb_reg_write && (id_rs1 == wb_rd))   id_rs1_data = wb_write_data;
        if (id_rs2 == '0)                             id_rs2_data = '0;
        else if (wb_reg_write && (id_rs2 == wb_rd))   id_rs2_data = wb_write_data;
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q;

    // An instruction retires when it leaves MEM/WB: replaced or flushed, not held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            retire_cnt_q <= '0;
        else if (memwb_q.valid && (flush || !stall)) retire_cnt_q <= retire_cnt_q + 64'd1;
    end

    assign retire_count = retire_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vector table, hand-written
// stall/flush/reset/bypass sequences and a randomized run against a reference model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid, mem_reg_write;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [63:0] mem_alu_result, mem_load_data, mem_pc_plus4;
    logic        stall, flush;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_write_data;
    logic [4:0]  id_rs1, id_rs2;
    logic [63:0] id_rf_data1, id_rf_data2, id_rs1_data, id_rs2_data;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_count;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk(clk), .reset_n(reset_n),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
        .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
        .mem_pc_plus4(mem_pc_plus4), .stall(stall), .flush(flush),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_write_data(wb_write_data),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rf_data1(id_rf_data1),
        .id_rf_data2(id_rf_data2), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data)
`ifdef WB_RETIRE_CNT_EN
        , .retire_count(retire_count)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Advance past the next rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] raw,
                         input logic [63:0] pc);
        mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
        mem_funct3 = f3; mem_alu_result = alu; mem_load_data = raw; mem_pc_plus4 = pc;
    endtask

    // Reference load extension from the size/sign rules, using casts.
    function automatic logic [63:0] ref_ext(input logic [2:0] f3, input logic [63:0] raw);
        case (f3)
            3'd0:    return 64'($signed(raw[7:0]));
            3'd1:    return 64'($signed(raw[15:0]));
            3'd2:    return 64'($signed(raw[31:0]));
            3'd4:    return 64'(raw[7:0]);
            3'd5:    return 64'(raw[15:0]);
            3'd6:    return 64'(raw[31:0]);
            default: return raw;
        endcase
    endfunction

    typedef struct {
        string       name;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [63:0] alu;
        logic [63:0] raw;
        logic [63:0] pc;
        logic [63:0] exp_data;
        logic        exp_we;
    } tv_t;

    localparam logic [63:0] RAW = 64'hFFFF_FFFF_FFFF_8081;

    tv_t tv[11];

    // Reference model state (architectural view of the MEM/WB contents).
    logic        m_valid, m_rw;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [2:0]  m_f3;
    logic [63:0] m_alu, m_raw, m_pc;
    logic [63:0] m_ret;

    function automatic logic [63:0] m_data();
        case (m_sel)
            2'd0:    return m_alu;
            2'd1:    return ref_ext(m_f3, m_raw);
            2'd2:    return m_pc;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic m_we();
        return m_valid && m_rw && (m_rd != 5'd0);
    endfunction

    function automatic logic [63:0] m_byp(input logic [4:0] rs, input logic [63:0] rf);
        if (rs == 5'd0) return 64'd0;
        if (m_we() && rs == m_rd) return m_data();
        return rf;
    endfunction

    initial begin
        tv[0]  = '{"alu_rd5",  5'd5, 2'd0, 3'd0, 64'h1234, 64'h0, 64'h0, 64'h1234, 1'b1};
        tv[1]  = '{"alu_rd0",  5'd0, 2'd0, 3'd0, 64'h1234, 64'h0, 64'h0, 64'h1234, 1'b0};
        tv[2]  = '{"lb",       5'd3, 2'd1, 3'd0, 64'h0, RAW, 64'h0, 64'hFFFF_FFFF_FFFF_FF81, 1'b1};
        tv[3]  = '{"lbu",      5'd3, 2'd1, 3'd4, 64'h0, RAW, 64'h0, 64'h81, 1'b1};
        tv[4]  = '{"lh",       5'd3, 2'd1, 3'd1, 64'h0, RAW, 64'h0, 64'hFFFF_FFFF_FFFF_8081, 1'b1};
        tv[5]  = '{"lhu",      5'd3, 2'd1, 3'd5, 64'h0, RAW, 64'h0, 64'h8081, 1'b1};
        tv[6]  = '{"lw",       5'd3, 2'd1, 3'd2, 64'h0, RAW, 64'h0, 64'hFFFF_FFFF_FFFF_8081, 1'b1};
        tv[7]  = '{"lwu",      5'd3, 2'd1, 3'd6, 64'h0, RAW, 64'h0, 64'hFFFF_8081, 1'b1};
        tv[8]  = '{"ld",       5'd3, 2'd1, 3'd3, 64'h0, 64'h8123_4567_89AB_CDEF, 64'h0, 64'h8123_4567_89AB_CDEF, 1'b1};
        tv[9]  = '{"pc4",      5'd1, 2'd2, 3'd0, 64'h77, 64'h0, 64'h1004, 64'h1004, 1'b1};
        tv[10] = '{"rsvd",     5'd2, 2'd3, 3'd0, 64'h77, RAW, 64'h1004, 64'h0, 1'b1};

        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rf_data1 = '0; id_rf_data2 = '0;
        stall = 1'b0; flush = 1'b0;

        // Reset held with active MEM inputs.
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 5'd4, 2'd0, 3'd0, 64'hDEAD, 64'h0, 64'h0);
        tick(); tick();
        chk("reset_we",   64'(wb_reg_write), 64'd0);
        chk("reset_data", wb_write_data, 64'd0);
        chk("reset_rd",   64'(wb_rd), 64'd0);
        // Release away from the edge; nothing is written before the first capture.
        #2 reset_n = 1'b1;
        #1 chk("post_release_we", 64'(wb_reg_write), 64'd0);
        tick();
        chk("first_capture_we", 64'(wb_reg_write), 64'd1);
        chk("first_capture_data", wb_write_data, 64'hDEAD);
        // Asynchronous reset mid-cycle clears outputs at once.
        #2 reset_n = 1'b0;
        #1 chk("async_reset_we", 64'(wb_reg_write), 64'd0);
        chk("async_reset_data", wb_write_data, 64'd0);
        #1 reset_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1'b1, tv[i].rd, tv[i].sel, tv[i].f3, tv[i].alu, tv[i].raw, tv[i].pc);
            tick();
            chk({tv[i].name, "_data"}, wb_write_data, tv[i].exp_data);
            chk({tv[i].name, "_we"},   64'(wb_reg_write), 64'(tv[i].exp_we));
        end

        // Stall holds the register for 3 cycles.
        drive(1'b1, 1'b1, 5'd9, 2'd0, 3'd0, 64'h55, 64'h0, 64'h0);
        tick();
        stall = 1'b1;
        drive(1'b1, 1'b1, 5'd12, 2'd2, 3'd0, 64'h99, 64'h0, 64'h4444);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_data", wb_write_data, 64'h55);
            chk("stall_hold_rd",   64'(wb_rd), 64'd9);
            chk("stall_hold_we",   64'(wb_reg_write), 64'd1);
        end
        // Flush beats stall.
        flush = 1'b1;
        tick();
        chk("stall_flush_we", 64'(wb_reg_write), 64'd0);
        stall = 1'b0; flush = 1'b0;

        // Bypass.
        drive(1'b1, 1'b1, 5'd7, 2'd0, 3'd0, 64'hAA, 64'h0, 64'h0);
        tick();
        id_rs1 = 5'd7; id_rf_data1 = 64'h11; id_rs2 = 5'd8; id_rf_data2 = 64'h22;
        #1;
        chk("byp_rs1_hit",  id_rs1_data, 64'hAA);
        chk("byp_rs2_miss", id_rs2_data, 64'h22);
        // A bubble no longer forwards.
        drive(1'b0, 1'b1, 5'd7, 2'd0, 3'd0, 64'hBB, 64'h0, 64'h0);
        tick();
        chk("byp_bubble", id_rs1_data, 64'h11);
        // x0 source with wb_rd = 0.
        drive(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 64'hCC, 64'h0, 64'h0);
        tick();
        id_rs1 = 5'd0;
        #1 chk("byp_x0", id_rs1_data, 64'd0);

`ifdef WB_RETIRE_CNT_EN
        // 4 valid instructions, 1 bubble, 2 stall cycles.
        reset_n = 1'b0; #1 reset_n = 1'b1;
        drive(1'b1, 1'b1, 5'd1, 2'd0, 3'd0, 64'h1, 64'h0, 64'h0);
        tick();                                   // I1 captured
        tick();                                   // I2 captured, I1 retires
        stall = 1'b1; tick(); tick(); stall = 1'b0;
        tick();                                   // I3 captured, I2 retires
        mem_valid = 1'b0; tick();                 // bubble, I3 retires
        mem_valid = 1'b1; tick();                 // I4 captured
        mem_valid = 1'b0; tick(); tick();         // I4 retires
        chk("retire_count_4", retire_count, 64'd4);
        // Wrap at 2^64.
        mem_valid = 1'b1; tick();
        force dut.retire_cnt_q = '1;
        #1 release dut.retire_cnt_q;
        tick();
        chk("retire_wrap", retire_count, 64'd0);
`endif

        // Randomized run against the reference model.
        reset_n = 1'b0; #1 reset_n = 1'b1;
        stall = 1'b0; flush = 1'b0;
        m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_f3 = 0; m_alu = 0; m_raw = 0; m_pc = 0;
        m_ret = 0;
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                  2'($urandom), 3'($urandom),
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_rf_data1 = {$urandom, $urandom}; id_rf_data2 = {$urandom, $urandom};
            @(posedge clk);
            if (m_valid && (flush || !stall)) m_ret = m_ret + 64'd1;
            if (flush) begin
                m_valid = 0; m_rw = 0; m_rd = 0; m_sel = 0; m_f3 = 0; m_alu = 0; m_raw = 0; m_pc = 0;
            end else if (!stall) begin
                m_valid = mem_valid; m_rw = mem_reg_write; m_rd = mem_rd; m_sel = mem_wb_sel;
                m_f3 = mem_funct3; m_alu = mem_alu_result; m_raw = mem_load_data; m_pc = mem_pc_plus4;
            end
            #1;
            chk("rnd_we", 64'(wb_reg_write), 64'(m_we()));
            if (m_we()) begin
                chk("rnd_rd",   64'(wb_rd), 64'(m_rd));
                chk("rnd_data", wb_write_data, m_data());
            end
            chk("rnd_byp1", id_rs1_data, m_byp(id_rs1, id_rf_data1));
            chk("rnd_byp2", id_rs2_data, m_byp(id_rs2, id_rf_data2));
        end
`ifdef WB_RETIRE_CNT_EN
        chk("rnd_retire", retire_count, m_ret);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
